jogada_timeout: RTL

Millisecond-resolution play timeout for PlaySeq, sitting directly downstream of the 50 MHz-to-1 kHz clock divider. It takes the divider's slow square-wave output, synchronizes it into the system clock domain and turns each rising edge into a one-cycle tick. It then counts those ticks while a play is in progress and flags a timeout when the configured limit is reached. The control unit starts, restarts and stops the timer and reads the timeout status.

---
 rtl/jogada_timeout_pkg.sv | 15 +
 rtl/sync_edge_detector.sv | 29 ++
 rtl/jogada_timeout.sv | 106 ++++++++++
 3 files changed

// File: rtl/jogada_timeout_pkg.sv
// Shared definitions for the PlaySeq play timeout: FSM state encoding and
// default sizing constants.
package jogada_timeout_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      CONTA    = 2'b01,
      ESGOTADO = 2'b10
   } estado_t;

   localparam int unsigned TIMEOUT_MS_DEFAULT = 3000;
   localparam int unsigned WARN_MS_DEFAULT    = 1000;
   localparam int unsigned WIDTH_DEFAULT      = 12;

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchronizer plus rising-edge detector; emits a registered one-cycle
// pulse per rising edge of an asynchronous input (divider output or button).
module sync_edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic s1_q, s2_q, s3_q, pulse_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= async_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         // s3 is the history of s2, so a high pulse is never followed by another
         pulse_q <= s2_q & ~s3_q;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/jogada_timeout.sv
// Millisecond play timeout: counts 1 kHz ticks while a play runs and flags
// timeout at TIMEOUT_MS. Optional warning output under JOGADA_TIMEOUT_WARN_EN.
module jogada_timeout
   import jogada_timeout_pkg::*;
#(
   parameter int unsigned TIMEOUT_MS = TIMEOUT_MS_DEFAULT,
   parameter int unsigned WIDTH      = WIDTH_DEFAULT
`ifdef JOGADA_TIMEOUT_WARN_EN
   ,
   parameter int unsigned WARN_MS    = WARN_MS_DEFAULT
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clk_1k,
   input  logic             iniciar,
   input  logic             zerar,
   input  logic             parar,
   output logic             tick_ms,
   output logic             contando,
   output logic             timeout,
   output logic [WIDTH-1:0] ms_count
`ifdef JOGADA_TIMEOUT_WARN_EN
   ,
   output logic             aviso
`endif
);

   localparam logic [WIDTH-1:0] CountMax = WIDTH'(TIMEOUT_MS - 1);

   estado_t          state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;

   sync_edge_detector u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (clk_1k),
      .pulse    (tick_ms)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Priority: parar > iniciar/zerar > tick
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (!parar && iniciar) begin
               state_d = CONTA;
               count_d = '0;
            end
         end
         CONTA: begin
            if (parar) begin
               state_d = IDLE;
            end else if (iniciar || zerar) begin
               count_d = '0;
            end else if (tick_ms) begin
               if (count_q == CountMax) begin
                  state_d = ESGOTADO;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         ESGOTADO: begin
            if (parar) begin
               state_d = IDLE;
            end else if (iniciar) begin
               state_d = CONTA;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      contando = (state_q == CONTA);
      timeout  = (state_q == ESGOTADO);
      ms_count = count_q;
   end

`ifdef JOGADA_TIMEOUT_WARN_EN
   // A margin at or beyond the full timeout puts the threshold at zero
   localparam int unsigned WarnThresh = (WARN_MS >= TIMEOUT_MS) ? 0 : (TIMEOUT_MS - WARN_MS);

   always_comb begin
      aviso = (state_q == ESGOTADO) ||
              ((state_q == CONTA) && (32'(count_q) >= WarnThresh));
   end
`endif

endmodule
